// File: rtl/tm_class_argmax.sv
// tm_class_argmax
//
// Decision stage of the TM classifier. When the classifier signals
// completion (rising edge of sums_valid), the ten signed class sums are
// latched. They are then scanned one class per cycle to find the
// largest. The winning class index and its sum are presented on a
// valid/ready handshake.
//
// Ports:
//   clk                     system clock, rising edge
//   rst_flag_n              synchronous active-low reset
//   class_sum_1..10         signed class sums (class_sum_k is class k-1)
//   sums_valid              classifier done level; a rising edge starts a decision
//   pred_ready              consumer accepts the prediction
//   pred_valid              prediction available
//   pred_class              winning class index 0..9
//   pred_sum                class sum of the winner
//   pred_margin             (TM_ARGMAX_MARGIN_EN only) best minus second-best sum
//   busy                    high while scanning or holding a prediction
//   overrun                 sticky: a start arrived while busy
//
// Optional feature macro: TM_ARGMAX_MARGIN_EN adds the pred_margin output
// and the second-best tracking logic.

module tm_class_argmax #(
  parameter int INT_SIZE    = 32,
  parameter int NUM_CLASSES = 10
) (
  input  logic                       clk,
  input  logic                       rst_flag_n,
  input  logic signed [INT_SIZE-1:0] class_sum_1,
  input  logic signed [INT_SIZE-1:0] class_sum_2,
  input  logic signed [INT_SIZE-1:0] class_sum_3,
  input  logic signed [INT_SIZE-1:0] class_sum_4,
  input  logic signed [INT_SIZE-1:0] class_sum_5,
  input  logic signed [INT_SIZE-1:0] class_sum_6,
  input  logic signed [INT_SIZE-1:0] class_sum_7,
  input  logic signed [INT_SIZE-1:0] class_sum_8,
  input  logic signed [INT_SIZE-1:0] class_sum_9,
  input  logic signed [INT_SIZE-1:0] class_sum_10,
  input  logic                       sums_valid,
  input  logic                       pred_ready,
  output logic                       pred_valid,
  output logic [3:0]                 pred_class,
  output logic signed [INT_SIZE-1:0] pred_sum,
  output logic                       busy,
`ifdef TM_ARGMAX_MARGIN_EN
  output logic [INT_SIZE:0]          pred_margin,
`endif
  output logic                       overrun
);

  localparam int CNT_W = $clog2(NUM_CLASSES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                     state_q, state_d;
  logic                       sv_q, sv_d;
  logic signed [INT_SIZE-1:0] sums_q [NUM_CLASSES];
  logic signed [INT_SIZE-1:0] sums_d [NUM_CLASSES];
  logic signed [INT_SIZE-1:0] sums_in [NUM_CLASSES];
  logic signed [INT_SIZE-1:0] best_sum_q, best_sum_d;
  logic [CNT_W-1:0]           best_idx_q, best_idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       pred_valid_q, pred_valid_d;
  logic [3:0]                 pred_class_q, pred_class_d;
  logic signed [INT_SIZE-1:0] pred_sum_q, pred_sum_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;
  logic                       start;
  logic signed [INT_SIZE-1:0] cur_sum;
`ifdef TM_ARGMAX_MARGIN_EN
  localparam logic signed [INT_SIZE-1:0] MIN_SUM = {1'b1, {(INT_SIZE-1){1'b0}}};
  logic signed [INT_SIZE-1:0] second_sum_q, second_sum_d;
  logic [INT_SIZE:0]          pred_margin_q, pred_margin_d;
`endif

  assign sums_in[0] = class_sum_1;
  assign sums_in[1] = class_sum_2;
  assign sums_in[2] = class_sum_3;
  assign sums_in[3] = class_sum_4;
  assign sums_in[4] = class_sum_5;
  assign sums_in[5] = class_sum_6;
  assign sums_in[6] = class_sum_7;
  assign sums_in[7] = class_sum_8;
  assign sums_in[8] = class_sum_9;
  assign sums_in[9] = class_sum_10;

  // sv_q was reset to 0, so a level already high at reset release is a start
  assign start = sums_valid & ~sv_q;

  // Guarded select so counter codes beyond the last class never index out of range
  always_comb begin
    cur_sum = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cnt_q == CNT_W'(i)) cur_sum = sums_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    sv_d         = sums_valid;
    sums_d       = sums_q;
    best_sum_d   = best_sum_q;
    best_idx_d   = best_idx_q;
    cnt_d        = cnt_q;
    pred_valid_d = pred_valid_q;
    pred_class_d = pred_class_q;
    pred_sum_d   = pred_sum_q;
    overrun_d    = overrun_q;
`ifdef TM_ARGMAX_MARGIN_EN
    second_sum_d  = second_sum_q;
    pred_margin_d = pred_margin_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          // Class 0 seeds the running best; the scan starts at class 1
          sums_d     = sums_in;
          best_sum_d = sums_in[0];
          best_idx_d = '0;
          cnt_d      = CNT_W'(1);
`ifdef TM_ARGMAX_MARGIN_EN
          second_sum_d = MIN_SUM;
`endif
          state_d    = SCAN;
        end
      end

      SCAN: begin
        if (start) overrun_d = 1'b1;
        // Strict compare: ties keep the earlier (lower) index
        if (cur_sum > best_sum_q) begin
          best_sum_d = cur_sum;
          best_idx_d = cnt_q;
`ifdef TM_ARGMAX_MARGIN_EN
          second_sum_d = best_sum_q;
        end else if (cur_sum > second_sum_q) begin
          // A tie with the best lands here, which drives the margin to zero
          second_sum_d = cur_sum;
`endif
        end
        cnt_d = cnt_q + CNT_W'(1);
        // The final compare and the output load happen on the same edge
        if (cnt_q == LAST_IDX) begin
          state_d      = DONE;
          pred_valid_d = 1'b1;
          pred_class_d = 4'(best_idx_d);
          pred_sum_d   = best_sum_d;
`ifdef TM_ARGMAX_MARGIN_EN
          pred_margin_d = {best_sum_d[INT_SIZE-1], best_sum_d}
                        - {second_sum_d[INT_SIZE-1], second_sum_d};
`endif
        end
      end

      DONE: begin
        if (start) overrun_d = 1'b1;
        if (pred_ready) begin
          pred_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_flag_n) begin
      state_q      <= IDLE;
      sv_q         <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) sums_q[i] <= '0;
      best_sum_q   <= '0;
      best_idx_q   <= '0;
      cnt_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_class_q <= '0;
      pred_sum_q   <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef TM_ARGMAX_MARGIN_EN
      second_sum_q  <= '0;
      pred_margin_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sv_q         <= sv_d;
      sums_q       <= sums_d;
      best_sum_q   <= best_sum_d;
      best_idx_q   <= best_idx_d;
      cnt_q        <= cnt_d;
      pred_valid_q <= pred_valid_d;
      pred_class_q <= pred_class_d;
      pred_sum_q   <= pred_sum_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
`ifdef TM_ARGMAX_MARGIN_EN
      second_sum_q  <= second_sum_d;
      pred_margin_q <= pred_margin_d;
`endif
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_class = pred_class_q;
  assign pred_sum   = pred_sum_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
`ifdef TM_ARGMAX_MARGIN_EN
  assign pred_margin = pred_margin_q;
`endif

endmodule

// File: tb/tb_tm_class_argmax.sv
// Testbench for tm_class_argmax. Expected predictions are computed from the
// driven sums when a decision is started, queued, and compared when the DUT
// raises pred_valid.

module tb_tm_class_argmax;

   logic                clk = 1'b0;
   logic                rstFlagN;
   logic signed [31:0]  stim [10];
   logic                sumsValid;
   logic                predReady;
   logic                predValid;
   logic [3:0]          predClass;
   logic signed [31:0]  predSum;
   logic                busy;
   logic                overrun;
`ifdef TM_ARGMAX_MARGIN_EN
   logic [32:0]         predMargin;
`endif

   typedef struct {
      logic [3:0]         cls;
      logic signed [31:0] sum;
      logic [32:0]        margin;
      longint             startCyc;
   } expect_t;

   expect_t scoreboard[$];
   int      assertCount = 0;
   int      failCount = 0;
   longint  cyc = 0;
   bit      prevValid = 1'b0;

   tm_class_argmax #(.INT_SIZE(32), .NUM_CLASSES(10)) dut (
      .clk(clk),
      .rst_flag_n(rstFlagN),
      .class_sum_1(stim[0]),
      .class_sum_2(stim[1]),
      .class_sum_3(stim[2]),
      .class_sum_4(stim[3]),
      .class_sum_5(stim[4]),
      .class_sum_6(stim[5]),
      .class_sum_7(stim[6]),
      .class_sum_8(stim[7]),
      .class_sum_9(stim[8]),
      .class_sum_10(stim[9]),
      .sums_valid(sumsValid),
      .pred_ready(predReady),
      .pred_valid(predValid),
      .pred_class(predClass),
      .pred_sum(predSum),
      .busy(busy),
`ifdef TM_ARGMAX_MARGIN_EN
      .pred_margin(predMargin),
`endif
      .overrun(overrun)
   );

   // Free-running clock and an edge counter used for latency measurement
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Counts one comparison and reports it when the observed value differs
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference argmax: first index holding the maximum; margin against the
   // largest of the remaining classes
   function automatic expect_t modelResult();
      expect_t            e;
      int                 best;
      logic signed [31:0] secondVal;
      best = 0;
      for (int i = 1; i < 10; i++) if (stim[i] > stim[best]) best = i;
      secondVal = 32'sh8000_0000;
      for (int i = 0; i < 10; i++) if (i != best && stim[i] > secondVal) secondVal = stim[i];
      e.cls = 4'(best);
      e.sum = stim[best];
      e.margin = 33'(longint'(stim[best]) - longint'(secondVal));
      e.startCyc = 0;
      return e;
   endfunction

   // Raises sums_valid so the next rising edge is the start edge
   task automatic applyStimulus(input bit expectResult);
      expect_t e;
      @(negedge clk);
      sumsValid = 1'b1;
      if (expectResult) begin
         e = modelResult();
         e.startCyc = cyc;
         scoreboard.push_back(e);
      end
   endtask

   task automatic lowerValid();
      @(negedge clk);
      sumsValid = 1'b0;
   endtask

   // Bounded wait for all queued predictions to be observed
   task automatic waitPrediction();
      for (int i = 0; i < 40; i++) begin
         if (scoreboard.size() == 0) break;
         @(negedge clk);
         #1;
      end
      checkOutput("pred_timeout", 64'(scoreboard.size()), 64'd0);
   endtask

   // Pops and compares an expectation on each new pred_valid assertion
   always @(negedge clk) begin
      expect_t e;
      if (predValid === 1'b1 && !prevValid) begin
         if (scoreboard.size() == 0) begin
            checkOutput("unexpected_pred", 64'd1, 64'd0);
         end else begin
            e = scoreboard.pop_front();
            checkOutput("pred_class", 64'(predClass), 64'(e.cls));
            checkOutput("pred_sum", 64'(predSum), 64'(e.sum));
            checkOutput("latency", 64'(cyc - e.startCyc), 64'd10);
`ifdef TM_ARGMAX_MARGIN_EN
            checkOutput("pred_margin", 64'(predMargin), 64'(e.margin));
`endif
         end
      end
      prevValid = (predValid === 1'b1);
   end

   initial begin
      rstFlagN = 1'b0;
      sumsValid = 1'b0;
      predReady = 1'b1;
      for (int i = 0; i < 10; i++) stim[i] = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_valid", 64'(predValid), 64'd0);
      checkOutput("rst_class", 64'(predClass), 64'd0);
      checkOutput("rst_sum", 64'(predSum), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_overrun", 64'(overrun), 64'd0);
`ifdef TM_ARGMAX_MARGIN_EN
      checkOutput("rst_margin", 64'(predMargin), 64'd0);
`endif
      rstFlagN = 1'b1;

      // Ties at the maximum resolve to the lower class index
      stim = '{32'sd5, -32'sd3, 32'sd12, 32'sd7, 32'sd0, 32'sd12, -32'sd100, 32'sd1, 32'sd2, 32'sd11};
      applyStimulus(1'b1);
      @(negedge clk);
      checkOutput("t1_busy_scan", 64'(busy), 64'd1);
      checkOutput("t1_valid_scan", 64'(predValid), 64'd0);
      waitPrediction();
      @(negedge clk);
      checkOutput("t1_valid_after_accept", 64'(predValid), 64'd0);
      checkOutput("t1_busy_after_accept", 64'(busy), 64'd0);
      checkOutput("t1_class_retained", 64'(predClass), 64'd2);
      checkOutput("t1_overrun", 64'(overrun), 64'd0);

      // Extreme negative values
      lowerValid();
      for (int i = 0; i < 9; i++) stim[i] = 32'sh8000_0000;
      stim[9] = 32'sh8000_0001;
      applyStimulus(1'b1);
      waitPrediction();

      // Outputs held while the consumer stalls
      lowerValid();
      stim = '{-32'sd7, 32'sd40, -32'sd9, 32'sd39, 32'sd0, 32'sd38, 32'sd1, 32'sd2, 32'sd3, -32'sd40};
      predReady = 1'b0;
      applyStimulus(1'b1);
      waitPrediction();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 64'(predValid), 64'd1);
         checkOutput("hold_class", 64'(predClass), 64'd1);
         checkOutput("hold_sum", 64'(predSum), 64'd40);
         checkOutput("hold_busy", 64'(busy), 64'd1);
`ifdef TM_ARGMAX_MARGIN_EN
         checkOutput("hold_margin", 64'(predMargin), 64'd1);
`endif
      end
      predReady = 1'b1;
      @(negedge clk);
      checkOutput("accept_valid", 64'(predValid), 64'd0);
      checkOutput("accept_busy", 64'(busy), 64'd0);
      checkOutput("accept_class", 64'(predClass), 64'd1);
      checkOutput("accept_sum", 64'(predSum), 64'd40);

      // A second start mid-scan with new inputs is ignored and flagged
      lowerValid();
      stim = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8, 32'sd100, 32'sd9};
      applyStimulus(1'b1);
      @(negedge clk);
      sumsValid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) stim[i] = 32'sd1000;
      sumsValid = 1'b1;
      waitPrediction();
      checkOutput("overrun_set", 64'(overrun), 64'd1);
      repeat (5) @(negedge clk);
      checkOutput("overrun_sticky", 64'(overrun), 64'd1);

      // Reset in the middle of a scan aborts with no prediction
      lowerValid();
      stim = '{32'sd10, 32'sd20, 32'sd30, 32'sd40, 32'sd50, 32'sd60, 32'sd70, 32'sd80, 32'sd90, 32'sd5};
      applyStimulus(1'b0);
      repeat (5) @(negedge clk);
      rstFlagN = 1'b0;
      sumsValid = 1'b0;
      @(negedge clk);
      rstFlagN = 1'b1;
      checkOutput("abort_valid", 64'(predValid), 64'd0);
      checkOutput("abort_class", 64'(predClass), 64'd0);
      checkOutput("abort_sum", 64'(predSum), 64'd0);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_overrun", 64'(overrun), 64'd0);
      repeat (15) @(negedge clk);
      checkOutput("abort_no_valid", 64'(predValid), 64'd0);
      stim = '{-32'sd1, -32'sd2, -32'sd3, -32'sd4, -32'sd5, -32'sd6, -32'sd7, -32'sd8, -32'sd9, -32'sd10};
      applyStimulus(1'b1);
      waitPrediction();

      // sums_valid already high when reset releases counts as one start
      lowerValid();
      @(negedge clk);
      rstFlagN = 1'b0;
      sumsValid = 1'b1;
      for (int i = 0; i < 10; i++) stim[i] = 32'(i);
      @(negedge clk);
      rstFlagN = 1'b1;
      begin
         expect_t e;
         e = modelResult();
         e.startCyc = cyc;
         scoreboard.push_back(e);
      end
      waitPrediction();
      repeat (30) @(negedge clk);
      checkOutput("level_busy", 64'(busy), 64'd0);
      checkOutput("level_valid", 64'(predValid), 64'd0);
      checkOutput("level_class", 64'(predClass), 64'd9);
      checkOutput("level_overrun", 64'(overrun), 64'd0);
      checkOutput("sb_empty", 64'(scoreboard.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
